imm_extend_pipe: RTL and testbench

Parametrised, pipelined immediate-extension unit. It takes an IN_W-bit immediate plus a mode and a sideband tag, and produces an OUT_W-bit extended value. It sits between the instruction decoder and the ALU operand mux / branch-target adder of the pipelined MIPS datapath. Valid/ready handshakes on both sides and a one-entry skid buffer give one-cycle latency and full throughput under backpressure.

---
 rtl/imm_ext_pkg.sv | 14 +
 rtl/imm_extend_core.sv | 34 +++
 rtl/imm_extend_pipe.sv | 109 ++++++++++
 tb/tb_imm_extend_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// Shared types and default widths for the immediate-extension pipeline.
package imm_ext_pkg;

    localparam int unsigned IMM_W  = 16;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        SIGN   = 2'b00,
        ZERO   = 2'b01,
        UPPER  = 2'b10,
        BRANCH = 2'b11
    } ext_mode_t;

endpackage : imm_ext_pkg

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: sign, zero, upper-placement and branch-offset forms.
module imm_extend_core
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_W,
    parameter int unsigned OUT_W = WORD_W
) (
    input  ext_mode_t          mode_i,
    input  logic [IN_W-1:0]    imm_i,
    output logic [OUT_W-1:0]   ext_c_o
);

    localparam int unsigned PAD_W = OUT_W - IN_W;

    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("imm_extend_core: OUT_W must be at least IN_W + 2");
    end

    logic [OUT_W-1:0] sext;

    // Select the extension form; sign extension is the shared base for SIGN and BRANCH.
    always_comb begin
        sext    = {{PAD_W{imm_i[IN_W-1]}}, imm_i};
        ext_c_o = sext;
        case (mode_i)
            SIGN:    ext_c_o = sext;
            ZERO:    ext_c_o = OUT_W'(imm_i);
            UPPER:   ext_c_o = {imm_i, {PAD_W{1'b0}}};
            BRANCH:  ext_c_o = {sext[OUT_W-3:0], 2'b00};
            default: ext_c_o = sext;
        endcase
    end

endmodule : imm_extend_core

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with valid/ready handshakes and a one-entry skid buffer.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int unsigned IN_W  = IMM_W,
    parameter int unsigned OUT_W = WORD_W,
    parameter int unsigned TAG_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_W-1:0]   in_imm,
    input  ext_mode_t         in_mode,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [TAG_W-1:0]  out_tag
);

    if (OUT_W < IN_W + 2) begin : g_bad_width
        $error("imm_extend_pipe: OUT_W must be at least IN_W + 2");
    end

    logic [OUT_W-1:0] ext_c;

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q,  out_data_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q,  skid_data_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    logic accept;
    logic drain;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .mode_i  (in_mode),
        .imm_i   (in_imm),
        .ext_c_o (ext_c)
    );

    // Ready depends only on reset and skid occupancy, never on out_ready.
    assign in_ready  = reset_n && !skid_valid_q;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

    // Next-state for out stage and skid: skid has priority into the out stage to keep FIFO order.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;

        if (!out_valid_q || drain) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
                if (accept) begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = ext_c;
                    skid_tag_d   = in_tag;
                end
            end else if (accept) begin
                out_valid_d = 1'b1;
                out_data_d  = ext_c;
                out_tag_d   = in_tag;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_c;
            skid_tag_d   = in_tag;
        end
    end

    // State registers with synchronous active-low reset; in-flight items are discarded.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

endmodule : imm_extend_pipe

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (16->32 and 8->16 instances).
module tb_imm_extend_pipe;
    import imm_ext_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_imm;
    ext_mode_t   in_mode;
    logic [4:0]  in_tag, out_tag;
    logic [31:0] out_data;

    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [7:0]  n_in_imm;
    ext_mode_t   n_in_mode;
    logic [4:0]  n_in_tag, n_out_tag;
    logic [15:0] n_out_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_imm    (in_imm),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    imm_extend_pipe #(.IN_W(8), .OUT_W(16), .TAG_W(5)) dut_n (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .in_imm    (n_in_imm),
        .in_mode   (n_in_mode),
        .in_tag    (n_in_tag),
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .out_data  (n_out_data),
        .out_tag   (n_out_tag)
    );

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent reference for the 16->32 configuration.
    function automatic logic [31:0] model(input ext_mode_t m, input logic [15:0] imm);
        logic signed [31:0] s;
        s = 32'($signed(imm));
        case (m)
            SIGN:    return s;
            ZERO:    return {16'h0000, imm};
            UPPER:   return {imm, 16'h0000};
            default: return s * 4;
        endcase
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        checks++; if (out_tag !== 5'h0) begin errors++; $display("FAIL reset_out_tag: got %h expected 00", out_tag); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", in_ready); end
        reset_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_modes();
        ext_mode_t   modes [6] = '{SIGN, SIGN, ZERO, UPPER, BRANCH, BRANCH};
        logic [15:0] imms  [6] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF, 16'h7FFF};
        logic [31:0] exps  [6] = '{32'hFFFF8000, 32'h00007FFF, 32'h00008000,
                                   32'h12340000, 32'hFFFFFFFC, 32'h0001FFFC};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_mode  = modes[i];
            in_imm   = imms[i];
            in_tag   = 5'(i + 3);
            step();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL modes_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL modes_data[%0d]: got %h expected %h", i, out_data, exps[i]); end
            checks++; if (out_tag !== 5'(i + 3)) begin errors++; $display("FAIL modes_tag[%0d]: got %0d expected %0d", i, out_tag, i + 3); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL modes_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = SIGN;
        in_imm    = 16'hFFF0;
        in_tag    = 5'd1;
        step();
        checks++; if (out_data !== 32'hFFFFFFF0 || out_tag !== 5'd1) begin errors++; $display("FAIL bp_a_loaded: got %h/%0d expected fffffff0/1", out_data, out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_c2: got %b expected 1", in_ready); end
        in_mode = ZERO;
        in_imm  = 16'hBEEF;
        in_tag  = 5'd2;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_c3: got %b expected 0", in_ready); end
        checks++; if (out_data !== 32'hFFFFFFF0 || out_tag !== 5'd1) begin errors++; $display("FAIL bp_hold_a: got %h/%0d expected fffffff0/1", out_data, out_tag); end
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hFFFFFFF0) begin errors++; $display("FAIL bp_stable: got %b/%h expected 1/fffffff0", out_valid, out_data); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000BEEF || out_tag !== 5'd2) begin errors++; $display("FAIL bp_b_out: got %b/%h/%0d expected 1/0000beef/2", out_valid, out_data, out_tag); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        ext_mode_t   m;
        logic [15:0] imm;
        logic [31:0] exp;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m   = ext_mode_t'($urandom_range(0, 3));
            imm = 16'($urandom);
            exp = model(m, imm);
            in_valid = 1'b1;
            in_mode  = m;
            in_imm   = imm;
            in_tag   = 5'(i + 10);
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== exp || out_tag !== 5'(i + 10)) begin
                errors++; $display("FAIL stream[%0d]: got %b/%h/%0d expected 1/%h/%0d", i, out_valid, out_data, out_tag, exp, i + 10);
            end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready); end
        end
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got %b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = UPPER;
        in_imm    = 16'h00AA;
        in_tag    = 5'd7;
        step();
        in_tag = 5'd8;
        step();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_skid_full: got %b expected 0", in_ready); end
        reset_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_reset: got %b expected 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0) begin errors++; $display("FAIL rmid_cleared: got %b/%h/%0d expected 0/00000000/0", out_valid, out_data, out_tag); end
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_after: got %b expected 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_stale[%0d]: got %b expected 0", i, out_valid); end
        end
    endtask

    task automatic test_narrow();
        ext_mode_t   modes [4] = '{SIGN, UPPER, ZERO, BRANCH};
        logic [7:0]  imms  [4] = '{8'h80, 8'hAB, 8'h80, 8'h80};
        logic [15:0] exps  [4] = '{16'hFF80, 16'hAB00, 16'h0080, 16'hFE00};
        n_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_in_valid = 1'b1;
            n_in_mode  = modes[i];
            n_in_imm   = imms[i];
            n_in_tag   = 5'(i + 20);
            step();
            checks++; if (n_out_valid !== 1'b1 || n_out_data !== exps[i] || n_out_tag !== 5'(i + 20)) begin
                errors++; $display("FAIL narrow[%0d]: got %b/%h/%0d expected 1/%h/%0d", i, n_out_valid, n_out_data, n_out_tag, exps[i], i + 20);
            end
        end
        n_in_valid = 1'b0;
        step();
        checks++; if (n_out_valid !== 1'b0 || n_in_ready !== 1'b1) begin errors++; $display("FAIL narrow_idle: got %b/%b expected 0/1", n_out_valid, n_in_ready); end
    endtask

    initial begin
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_imm      = '0;
        in_mode     = SIGN;
        in_tag      = '0;
        out_ready   = 1'b0;
        n_in_valid  = 1'b0;
        n_in_imm    = '0;
        n_in_mode   = SIGN;
        n_in_tag    = '0;
        n_out_ready = 1'b0;

        test_reset();
        test_modes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_narrow();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_imm_extend_pipe
